// File: rtl/mdu_unit_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: start codes,
// HI/LO read select and FSM states, also referenced by the controller and ID/EX.
package mdu_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  localparam logic HL_SEL_HI = 1'b1;
  localparam logic HL_SEL_LO = 1'b0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Multi-cycle ops are mult/multu/div/divu; everything else is single-edge or none.
  function automatic logic is_md_multicycle(input logic [3:0] code);
    return (code == MD_MULT) || (code == MD_MULTU) ||
           (code == MD_DIV)  || (code == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// MIPS multiply/divide unit: computes mult/div results at issue, holds them in
// shadow registers for the modelled latency, then commits to architectural HI/LO.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  start,
  input  logic        HLSel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HLOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  logic               r_pend_we;

  logic signed [63:0] w_smul;
  logic [63:0]        w_umul;
  logic               w_sdiv_ovf;
  logic [31:0]        w_sdivisor;
  logic [31:0]        w_udivisor;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic [31:0]        w_uquot;
  logic [31:0]        w_urem;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_res_we;
  logic [CNT_W-1:0]   w_load_cnt;

  assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_umul = {32'd0, A} * {32'd0, B};

  // Dividing by 1 in the overflow case yields exactly the required
  // quotient 0x80000000 and remainder 0; the zero-divisor guard only keeps
  // the datapath X-free, since that result is never committed.
  assign w_sdiv_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_sdivisor = ((B == 32'd0) || w_sdiv_ovf) ? 32'd1 : B;
  assign w_udivisor = (B == 32'd0) ? 32'd1 : B;

  assign w_squot = $signed(A) / $signed(w_sdivisor);
  assign w_srem  = $signed(A) % $signed(w_sdivisor);
  assign w_uquot = A / w_udivisor;
  assign w_urem  = A % w_udivisor;

  always_comb begin
    w_res_hi   = 32'd0;
    w_res_lo   = 32'd0;
    w_res_we   = 1'b0;
    w_load_cnt = CNT_W'(MULT_CYCLES);
    case (start)
      MD_MULT: begin
        w_res_hi = w_smul[63:32];
        w_res_lo = w_smul[31:0];
        w_res_we = 1'b1;
      end
      MD_MULTU: begin
        w_res_hi = w_umul[63:32];
        w_res_lo = w_umul[31:0];
        w_res_we = 1'b1;
      end
      MD_DIV: begin
        w_res_hi   = w_srem;
        w_res_lo   = w_squot;
        w_res_we   = (B != 32'd0);
        w_load_cnt = CNT_W'(DIV_CYCLES);
      end
      MD_DIVU: begin
        w_res_hi   = w_urem;
        w_res_lo   = w_uquot;
        w_res_we   = (B != 32'd0);
        w_load_cnt = CNT_W'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (is_md_multicycle(start)) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_we <= w_res_we;
            r_cnt     <= w_load_cnt;
            r_state   <= BUSY;
          end else if (start == MD_MTHI) begin
            r_hi <= A;
          end else if (start == MD_MTLO) begin
            r_lo <= A;
          end
        end
        BUSY: begin
          // Start codes are ignored here; the hazard unit never issues them.
          if (r_cnt == CNT_W'(1)) begin
            if (r_pend_we) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = (r_state == BUSY);
  assign HLOut = (HLSel == HL_SEL_HI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, hand-written
// corner sequences, and random ops against a plain-arithmetic HI/LO model.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  start = 4'd0;
  logic        HLSel = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HLOut;

  int vectors = 0;
  int miscompares = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .HLSel(HLSel),
    .A(A), .B(B), .busy(busy), .HLOut(HLOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl[14];

  logic [31:0] m_hi, m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
    HLSel = 1'b1; #1 hi = HLOut;
    HLSel = 1'b0; #1 lo = HLOut;
  endtask

  // Issue one op on the next edge and count busy cycles (bounded).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nbusy);
    @(negedge clk);
    start = op; A = a; B = b;
    @(negedge clk);
    start = 4'd0;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  function automatic int model_busy(input logic [3:0] op);
    if (op == MD_MULT || op == MD_MULTU) return 5;
    if (op == MD_DIV || op == MD_DIVU) return 10;
    return 0;
  endfunction

  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    case (op)
      MD_MULT:  begin sq = sa * sb; m_hi = sq[63:32]; m_lo = sq[31:0]; end
      MD_MULTU: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      MD_DIV:   if (b != 0) begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      MD_DIVU:  if (b != 0) begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
      MD_MTHI:  m_hi = a;
      MD_MTLO:  m_lo = a;
      default: ;
    endcase
  endtask

  initial begin
    int nb;
    int seen;
    logic [31:0] hi, lo;
    logic [3:0] op;
    logic [31:0] ra, rb;

    tbl[0]  = '{MD_MULT,  32'd7,          32'd6,          5,  32'h0,        32'd42};
    tbl[1]  = '{MD_MULT,  32'hFFFFFFFF,   32'd2,          5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[2]  = '{MD_MULTU, 32'hFFFFFFFF,   32'd2,          5,  32'h00000001, 32'hFFFFFFFE};
    tbl[3]  = '{MD_DIV,   32'hFFFFFFF9,   32'd2,          10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4]  = '{MD_DIV,   32'h80000000,   32'hFFFFFFFF,   10, 32'h0,        32'h80000000};
    tbl[5]  = '{MD_MTHI,  32'h12345678,   32'd0,          0,  32'h12345678, 32'h80000000};
    tbl[6]  = '{MD_MTLO,  32'hCAFEBABE,   32'd0,          0,  32'h12345678, 32'hCAFEBABE};
    tbl[7]  = '{MD_DIVU,  32'd55,         32'd0,          10, 32'h12345678, 32'hCAFEBABE};
    tbl[8]  = '{MD_NONE,  32'd1,          32'd1,          0,  32'h12345678, 32'hCAFEBABE};
    tbl[9]  = '{4'd9,     32'd1,          32'd1,          0,  32'h12345678, 32'hCAFEBABE};
    tbl[10] = '{4'd15,    32'd1,          32'd1,          0,  32'h12345678, 32'hCAFEBABE};
    tbl[11] = '{MD_DIVU,  32'd100,        32'd7,          10, 32'd2,        32'd14};
    tbl[12] = '{MD_DIV,   32'd7,          32'd0,          10, 32'd2,        32'd14};
    tbl[13] = '{MD_MULT,  32'h80000000,   32'h80000000,   5,  32'h40000000, 32'h0};

    // Reset state
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    read_hl(hi, lo);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, nb);
      read_hl(hi, lo);
      $display("vec %0d op=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h", i, tbl[i].op,
               tbl[i].a, tbl[i].b, nb, hi, lo);
      chk($sformatf("tbl%0d_busy", i), nb, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_hi", i), hi, tbl[i].exp_hi);
      chk($sformatf("tbl%0d_lo", i), lo, tbl[i].exp_lo);
    end

    // Back-to-back mthi/mtlo: busy never rises
    @(negedge clk);
    start = MD_MTHI; A = 32'hA5A5A5A5;
    @(negedge clk);
    chk("mthi_nobusy", {31'd0, busy}, 32'd0);
    start = MD_MTLO; A = 32'h5A5A5A5A;
    @(negedge clk);
    chk("mtlo_nobusy", {31'd0, busy}, 32'd0);
    start = MD_NONE;
    read_hl(hi, lo);
    $display("mthi/mtlo pair hi=%08h lo=%08h", hi, lo);
    chk("pair_hi", hi, 32'hA5A5A5A5);
    chk("pair_lo", lo, 32'h5A5A5A5A);

    // start=multu at busy cycle 3 of a mult is ignored
    @(negedge clk);
    start = MD_MULT; A = 32'd3; B = 32'd5;
    @(negedge clk);
    start = MD_NONE;
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      if (nb == 3) begin start = MD_MULTU; A = 32'd1000; B = 32'd1000; end
      else start = MD_NONE;
      if (nb == 4) begin
        read_hl(hi, lo);
        chk("busy_old_lo", lo, 32'h5A5A5A5A);
      end
      @(negedge clk);
    end
    start = MD_NONE;
    read_hl(hi, lo);
    $display("ignored-start mult busy=%0d hi=%08h lo=%08h", nb, hi, lo);
    chk("ign_busy", nb, 5);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd15);
    @(negedge clk);
    chk("ign_after_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset at busy cycle 2 of a div
    @(negedge clk);
    start = MD_DIV; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    start = MD_NONE;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("areset_busy", {31'd0, busy}, 32'd0);
    read_hl(hi, lo);
    $display("async reset mid-div busy=%0b hi=%08h lo=%08h", busy, hi, lo);
    chk("areset_hi", hi, 32'd0);
    chk("areset_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;
    do_op(MD_DIVU, 32'd100, 32'd7, nb);
    read_hl(hi, lo);
    $display("post-reset divu busy=%0d hi=%08h lo=%08h", nb, hi, lo);
    chk("prst_busy", nb, 10);
    chk("prst_hi", hi, 32'd2);
    chk("prst_lo", lo, 32'd14);

    // Random ops against the arithmetic model
    m_hi = 32'd2; m_lo = 32'd14;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op > 4'd6 && $urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 6));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      do_op(op, ra, rb, nb);
      model_apply(op, ra, rb);
      read_hl(hi, lo);
      $display("rnd %0d op=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h", i, op, ra, rb, nb, hi, lo);
      chk($sformatf("rnd%0d_busy", i), nb, model_busy(op));
      chk($sformatf("rnd%0d_hi", i), hi, m_hi);
      chk($sformatf("rnd%0d_lo", i), lo, m_lo);
    end

    seen = 0;
    repeat (3) @(negedge clk);
    seen = int'(busy);
    chk("final_idle", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
